// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional zero register, write-through bypass and debug dump engine.
// Latency: reads are combinational (0 cycles); writes land on the next rising edge; dump words follow start by one edge.
// Backpressure: dump stream is valid/ready; the current word holds while dump_ready=0 (it still reflects new writes).
//
// Ports:
//   clk, rst (async, active-low)
//   en, we, waddr, wdata            : write port (en=0 stalls the write only)
//   raddr, rdata                    : NREAD packed combinational read ports
//   dump_start                      : request to stream every register
//   dump_valid/ready/idx/data       : dump stream handshake and payload
//   dump_busy, dump_done            : engine status; done pulses once after the last word is accepted
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NREAD*ADDR_W-1:0]  raddr,
    output logic [NREAD*DATA_W-1:0]  rdata,
    input  logic                     dump_start,
    input  logic                     dump_ready,
    output logic                     dump_valid,
    output logic [ADDR_W-1:0]        dump_idx,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_busy,
    output logic                     dump_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              commit;
    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;

    // A write to the zero register is dropped entirely, so it never commits
    // and never reaches the bypass path either.
    assign commit = we && en && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[waddr] <= wdata;
        end
    end

    // Shared read path used by every read port and the dump engine:
    // zero register first, then same-cycle forwarding, then stored value.
    function automatic logic [DATA_W-1:0] rd_mux(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              wr_commit,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        logic [DATA_W-1:0] r;
        if ((ZERO_REG != 0) && (a == '0)) begin
            r = '0;
        end else if ((BYPASS != 0) && wr_commit && (wr_addr == a)) begin
            r = wr_data;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = raddr[p*ADDR_W +: ADDR_W];
        assign rdata[p*DATA_W +: DATA_W] = rd_mux(a, regs[a], commit, waddr, wdata);
    end

    // Dump engine: IDLE -> SEND (one word per accepted handshake) -> DONE -> IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dump_start) begin
                        state <= ST_SEND;
                        idx   <= '0;
                    end
                end
                ST_SEND: begin
                    if (dump_ready) begin
                        if (idx == ADDR_W'(DEPTH - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign dump_valid = (state == ST_SEND);
    assign dump_busy  = (state != ST_IDLE);
    assign dump_done  = (state == ST_DONE);
    assign dump_idx   = idx;
    // Live view of the register: a write landing on the held index shows up
    // before the word is accepted.
    assign dump_data  = rd_mux(idx, regs[idx], commit, waddr, wdata);

endmodule
